// File: rtl/reg_file_sb_pkg.sv
// Shared sizing constants and helpers for the CRP16 register file with scoreboard.
package crp16_rf_pkg;

    localparam int RF_WIDTH  = 16;
    localparam int RF_ADDR_W = 3;

    function automatic int rf_nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Register-file access bus: one write port, one claim port, two read ports, scoreboard view.
interface reg_file_sb_if
    import crp16_rf_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int ADDR_W = RF_ADDR_W
);
    localparam int NREGS = rf_nregs(ADDR_W);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [WIDTH-1:0]  rd_data_a;
    logic              rd_busy_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rd_busy_b;
    logic              claim_en;
    logic [ADDR_W-1:0] claim_addr;
    logic [NREGS-1:0]  busy_vec;
    logic              any_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, claim_en, claim_addr,
        input  rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, busy_vec, any_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, claim_en, claim_addr,
        output rd_data_a, rd_busy_a, rd_data_b, rd_busy_b, busy_vec, any_busy
    );

endinterface

// File: rtl/reg_file_sb_cell.sv
// One register of the file: WIDTH-bit data plus its pending-write busy bit.
module reg_file_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_wr_sel,
    input  logic             i_claim_sel,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy
);

    logic [WIDTH-1:0] r_data;
    logic             r_busy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
        end else if (i_wr_sel) begin
            r_data <= i_wr_data;
        end
    end

    // A claim on the same edge as the completing write re-arms the bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
        end else if (i_claim_sel) begin
            r_busy <= 1'b1;
        end else if (i_wr_sel) begin
            r_busy <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_busy = r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// CRP16 general-purpose register file: 2 async reads, 1 sync write, per-register busy scoreboard.
module reg_file_sb
    import crp16_rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    reg_file_sb_if.slave bus
);

    localparam int NREGS = rf_nregs(ADDR_W);

    logic [NREGS-1:0] w_wr_sel;
    logic [NREGS-1:0] w_claim_sel;
    logic [NREGS-1:0] w_busy;
    logic [WIDTH-1:0] w_data [NREGS];

    logic [ADDR_W-1:0] w_rd_addr  [2];
    logic [WIDTH-1:0]  w_rd_data  [2];
    logic              w_rd_busy  [2];

    // Register 0 is never selected when hardwired, so it stays at reset value.
    always_comb begin
        w_wr_sel    = '0;
        w_claim_sel = '0;
        if (bus.wr_en) begin
            w_wr_sel[bus.wr_addr] = 1'b1;
        end
        if (bus.claim_en) begin
            w_claim_sel[bus.claim_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            w_wr_sel[0]    = 1'b0;
            w_claim_sel[0] = 1'b0;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_cell
        reg_file_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clock       (clock),
            .reset       (reset),
            .i_wr_sel    (w_wr_sel[i]),
            .i_claim_sel (w_claim_sel[i]),
            .i_wr_data   (bus.wr_data),
            .o_data      (w_data[i]),
            .o_busy      (w_busy[i])
        );
    end

    assign w_rd_addr[0] = bus.rd_addr_a;
    assign w_rd_addr[1] = bus.rd_addr_b;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic w_wr_hit;
        logic w_claim_hit;

        assign w_wr_hit    = bus.wr_en    && (bus.wr_addr    == w_rd_addr[p]);
        assign w_claim_hit = bus.claim_en && (bus.claim_addr == w_rd_addr[p]);

        // Zero register overrides bypass; bypassed data is only valid if not re-claimed.
        always_comb begin
            w_rd_data[p] = w_data[w_rd_addr[p]];
            w_rd_busy[p] = w_busy[w_rd_addr[p]];
            if (BYPASS && w_wr_hit) begin
                w_rd_data[p] = bus.wr_data;
                if (!w_claim_hit) begin
                    w_rd_busy[p] = 1'b0;
                end
            end
            if (ZERO_REG && (w_rd_addr[p] == '0)) begin
                w_rd_data[p] = '0;
            end
        end
    end

    assign bus.rd_data_a = w_rd_data[0];
    assign bus.rd_busy_a = w_rd_busy[0];
    assign bus.rd_data_b = w_rd_data[1];
    assign bus.rd_busy_b = w_rd_busy[1];
    assign bus.busy_vec  = w_busy;
    assign bus.any_busy  = |w_busy;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-port general-purpose register file for the CRP16 datapath, with an integrated pending-write scoreboard.
- Provides two asynchronous read ports and one synchronous write port.
- Optional hardwired zero register and optional write-to-read bypass.
- Per-register busy bits let the pipeline control detect read-after-write hazards on in-flight results.

Parameters:
- WIDTH, 16, data width of each register in bits.
- ADDR_W, 3, address width; register count NREGS = 2**ADDR_W.
- ZERO_REG, 0, 1 = register 0 always reads 0, and writes and claims to it are ignored.
- BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data combinationally.

Ports:
- clock  input  1  clock source, positive edge.
- reset  input  1  asynchronous, active-low; 0 clears all registers and busy bits.
- wr_en  input  1  1 = write wr_data to wr_addr on the rising edge.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WIDTH  write data.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_data_a  output  WIDTH  read port A data.
- rd_busy_a  output  1  busy bit of rd_addr_a.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_b  output  WIDTH  read port B data.
- rd_busy_b  output  1  busy bit of rd_addr_b.
- claim_en  input  1  1 = mark claim_addr as having a pending write.
- claim_addr  input  ADDR_W  register being claimed.
- busy_vec  output  NREGS  all busy bits; bit i corresponds to register i.
- any_busy  output  1  OR of busy_vec.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers = 0, all busy bits = 0.
  - rd_data_a/b = 0 for any address, unless bypass is active.
  - rd_busy_a/b = 0, busy_vec = 0, any_busy = 0.
  - Reset is held as long as reset=0. Writes and claims presented during reset are discarded.
- Reset mid-operation: asserting reset at any point clears all state immediately, with no clock needed. A write and reset on the same edge leaves the register at 0.
- Write:
  - Registers update on the rising clock edge when wr_en=1 and reset=1. Write latency is one cycle.
  - When wr_en=0, registers hold their value.
- Read: fully combinational from rd_addr_x, with no clock latency.
  - Read data without bypass: rd_data_x = reg[rd_addr_x].
  - BYPASS=1: if wr_en=1 and wr_addr==rd_addr_x, rd_data_x = wr_data in the same cycle.
  - BYPASS=0: the old value is returned until the edge.
  - Both ports may read the same address.
- Zero register (ZERO_REG=1):
  - rd_data_x = 0 whenever rd_addr_x = 0, taking precedence over bypass.
  - Writes to address 0 are dropped, and busy bit 0 is constantly 0.
- Scoreboard, per register i:
  - Set on an edge with claim_en=1 and claim_addr=i.
  - Cleared on an edge with wr_en=1 and wr_addr=i.
  - Same edge, same address, claim and write both active: the write updates the data, and the busy bit ends at 1, because the new claim wins.
  - Same edge, different addresses: both actions take effect independently.
  - Claiming an already-busy register leaves it at 1; the scoreboard is a single bit, with no count.
  - Writing a non-busy register is legal and leaves its busy bit at 0.
- Busy outputs:
  - rd_busy_x = busy[rd_addr_x], combinational.
  - BYPASS=1: rd_busy_x is forced to 0 when the current-cycle write targets rd_addr_x and no same-cycle claim targets it. This means the bypassed data is valid.
- Arithmetic: no arithmetic is performed. Address decode is one-hot over NREGS, and addresses are always in range by construction.

Decomposition:
- Package crp16_rf_pkg holds:
  - default constants RF_WIDTH=16 and RF_ADDR_W=3;
  - a function to compute NREGS from ADDR_W.
- One natural sub-module, reg_file_cell. It holds one WIDTH-bit data register plus its busy bit, and has:
  - active-low asynchronous reset;
  - inputs: write-select, claim-select, data.
- reg_file_sb instantiates NREGS cells through a generate loop. It contains the decode logic, the read muxes, the bypass/zero logic and the busy OR-reduction.

Test Plan:
- Reset and basic write: pulse reset low, then release it. Write 0x1234 to r3, then read r3 on port A and r0 on port B.
  - Required response: before the write, all reads are 0 and busy_vec=0. One cycle after the write, rd_data_a=0x1234. rd_data_b=0.
- Bypass: with BYPASS=1, in the same cycle set wr_en=1, wr_addr=5, wr_data=0xBEEF and rd_addr_a=5.
  - Required response: rd_data_a=0xBEEF before the edge. With BYPASS=0, the old value (0) is returned until the edge.
- Zero register: with ZERO_REG=1, write 0xFFFF to r0 and claim r0.
  - Required response: r0 reads 0 on both ports, busy_vec[0]=0, any_busy=0.
- Scoreboard lifecycle: claim r2. Then write r2 with 0x00AA two cycles later.
  - Required response: rd_busy_a=1 for rd_addr_a=2 during the gap. Busy clears after the write edge. rd_data_a=0x00AA.
- Simultaneous events: with r4 busy, apply claim_addr=4 and wr_addr=4, wr_data=0x5555 on the same edge.
  - Required response: reg4=0x5555, busy bit 4 stays 1.
  - A separate edge with claim r1 and write r6 sets busy[1] and clears busy[6].
- Reset mid-operation: with r1..r7 written and busy bits set, drive reset low between clock edges.
  - Required response: all data and busy outputs go to 0 immediately, before the next edge. A write on the first edge after release takes effect normally.
